// File: rtl/alu_pkg.sv
// Shared constants for the two-requester ALU arbiter: select codes, default widths
// and requester IDs.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SEL_W = 3;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b100;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels for both requesters of the shared ALU.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
);

  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SEL_W-1:0] req0_sel, req1_sel;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic             rsp0_zero, rsp1_zero;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_sel, req1_sel, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_result, rsp1_result, rsp0_zero, rsp1_zero
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_sel, req1_sel, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_result, rsp1_result, rsp0_zero, rsp1_zero
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: add, sub, and, or, unsigned less-than; unused selects give 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (sel)
      SEL_W'(ALU_ADD):  result = data1 + data2;
      SEL_W'(ALU_SUB):  result = data1 - data2;
      SEL_W'(ALU_AND):  result = data1 & data2;
      SEL_W'(ALU_OR):   result = data1 | data2;
      SEL_W'(ALU_SLTU): result = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      default:          result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a one-entry
// result slot that returns each result on the owner's response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  slot_state_e      state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             owner_rsp_ready;
  logic             slot_free;
  logic             grant;
  logic             xfer;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [SEL_W-1:0] alu_sel;
  logic             alu_zero;

  // A full slot frees up on the same edge its owner consumes it.
  assign owner_rsp_ready = (owner_q == REQ1) ? bus.rsp1_ready : bus.rsp0_ready;
  assign slot_free       = (state_q == SLOT_EMPTY) || owner_rsp_ready;

  always_comb begin
    grant = ~last_grant_q;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else if (bus.req1_valid)              grant = REQ1;
    else if (bus.req0_valid)              grant = REQ0;
  end

  assign bus.req0_ready = rst_n & slot_free & (grant == REQ0);
  assign bus.req1_ready = rst_n & slot_free & (grant == REQ1);
  assign xfer = (grant == REQ1) ? (bus.req1_valid & bus.req1_ready)
                                : (bus.req0_valid & bus.req0_ready);

  assign alu_a   = (grant == REQ1) ? bus.req1_a   : bus.req0_a;
  assign alu_b   = (grant == REQ1) ? bus.req1_b   : bus.req0_b;
  assign alu_sel = (grant == REQ1) ? bus.req1_sel : bus.req0_sel;

  alu_core #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_alu_core (
    .data1  (alu_a),
    .data2  (alu_b),
    .sel    (alu_sel),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    zero_d       = zero_q;
    if (xfer) begin
      state_d      = SLOT_FULL;
      owner_d      = grant;
      last_grant_d = grant;
      result_d     = alu_result;
      zero_d       = alu_zero;
    end else if ((state_q == SLOT_FULL) && owner_rsp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SLOT_EMPTY;
      owner_q      <= REQ0;
      last_grant_q <= REQ1;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  assign bus.rsp0_valid  = (state_q == SLOT_FULL) && (owner_q == REQ0);
  assign bus.rsp1_valid  = (state_q == SLOT_FULL) && (owner_q == REQ1);
  assign bus.rsp0_result = bus.rsp0_valid ? result_q : '0;
  assign bus.rsp1_result = bus.rsp1_valid ? result_q : '0;
  assign bus.rsp0_zero   = bus.rsp0_valid & zero_q;
  assign bus.rsp1_zero   = bus.rsp1_valid & zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: reset, ALU ops, round-robin,
// backpressure and asynchronous mid-operation reset.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_arbiter_if #(.WIDTH(32), .SEL_W(3)) bus ();

  alu_arbiter #(.WIDTH(32), .SEL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0;
  endtask

  // Presents one request for a single clock edge, then withdraws it.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel);
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req0_ready got=%b exp=0", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req1_ready got=%b exp=0", bus.req1_ready); end
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rsp0_valid got=%b exp=0", bus.rsp0_valid); end
    n_cmp++; if (bus.rsp1_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rsp1_valid got=%b exp=0", bus.rsp1_valid); end
    n_cmp++; if (bus.rsp0_result !== 32'h0 || bus.rsp0_zero !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rsp0_data got=%h/%b exp=0/0", bus.rsp0_result, bus.rsp0_zero); end
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    bus.rsp0_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd5; bus.req0_sel = 3'b000;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("[TB] FAIL add_req0_ready got=%b exp=1", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("[TB] FAIL add_req1_ready got=%b exp=0", bus.req1_ready); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n_cmp++; if (bus.rsp0_valid !== 1'b1) begin n_err++; $display("[TB] FAIL add_rsp0_valid got=%b exp=1", bus.rsp0_valid); end
    n_cmp++; if (bus.rsp0_result !== 32'd12) begin n_err++; $display("[TB] FAIL add_result got=%h exp=%h", bus.rsp0_result, 32'd12); end
    n_cmp++; if (bus.rsp0_zero !== 1'b0) begin n_err++; $display("[TB] FAIL add_zero got=%b exp=0", bus.rsp0_zero); end
    n_cmp++; if (bus.rsp1_valid !== 1'b0 || bus.rsp1_result !== 32'h0) begin n_err++; $display("[TB] FAIL add_rsp1_quiet got=%b/%h exp=0/0", bus.rsp1_valid, bus.rsp1_result); end
    idle_cycle();
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_err++; $display("[TB] FAIL add_drained got=%b exp=0", bus.rsp0_valid); end
  endtask

  task automatic test_sub();
    bus.rsp1_ready = 1'b1;
    issue(1, 32'd5, 32'd5, 3'b001);
    n_cmp++; if (bus.rsp1_valid !== 1'b1) begin n_err++; $display("[TB] FAIL sub_eq_valid got=%b exp=1", bus.rsp1_valid); end
    n_cmp++; if (bus.rsp1_result !== 32'h0 || bus.rsp1_zero !== 1'b1) begin n_err++; $display("[TB] FAIL sub_eq got=%h/%b exp=0/1", bus.rsp1_result, bus.rsp1_zero); end
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_err++; $display("[TB] FAIL sub_rsp0_quiet got=%b exp=0", bus.rsp0_valid); end
    issue(1, 32'd3, 32'd5, 3'b001);
    n_cmp++; if (bus.rsp1_result !== 32'hFFFF_FFFE || bus.rsp1_zero !== 1'b0) begin n_err++; $display("[TB] FAIL sub_wrap got=%h/%b exp=fffffffe/0", bus.rsp1_result, bus.rsp1_zero); end
    issue(1, 32'd9, 32'd4, 3'b101);
    n_cmp++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 32'h0 || bus.rsp1_zero !== 1'b1) begin n_err++; $display("[TB] FAIL sel101 got=%b/%h/%b exp=1/0/1", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_zero); end
  endtask

  task automatic test_round_robin();
    logic exp_id;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'hF0; bus.req0_b = 32'h3C; bus.req0_sel = 3'b010;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd2;  bus.req1_b = 32'hFFFF_FFFF; bus.req1_sel = 3'b100;
    exp_id = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin n_err++; $display("[TB] FAIL rr_ready[%0d] got=%b%b exp_grant=%0d", i, bus.req1_ready, bus.req0_ready, exp_id); end
      @(posedge clk); #1;
      if (exp_id == 1'b0) begin
        n_cmp++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_result !== 32'h30) begin n_err++; $display("[TB] FAIL rr_rsp0[%0d] got=%b%b/%h exp=01/30", i, bus.rsp1_valid, bus.rsp0_valid, bus.rsp0_result); end
      end else begin
        n_cmp++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_result !== 32'h1) begin n_err++; $display("[TB] FAIL rr_rsp1[%0d] got=%b%b/%h exp=10/1", i, bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_result); end
      end
      exp_id = ~exp_id;
    end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
    issue(0, 32'd7, 32'd5, 3'b000);
    bus.req1_valid = 1'b1; bus.req1_a = 32'd6; bus.req1_b = 32'd3; bus.req1_sel = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_ready[%0d] got=%b%b exp=00", i, bus.req1_ready, bus.req0_ready); end
      n_cmp++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'd12) begin n_err++; $display("[TB] FAIL bp_hold[%0d] got=%b/%h exp=1/c", i, bus.rsp0_valid, bus.rsp0_result); end
      @(posedge clk);
    end
    #1;
    bus.rsp0_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_release_ready got=%b exp=1", bus.req1_ready); end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    n_cmp++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_result !== 32'd2) begin n_err++; $display("[TB] FAIL bp_handoff got=%b%b/%h exp=10/2", bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_result); end
    idle_cycle();
  endtask

  task automatic test_sltu_or();
    bus.rsp0_ready = 1'b1;
    issue(0, 32'h8000_0000, 32'd1, 3'b100);
    n_cmp++; if (bus.rsp0_result !== 32'h0 || bus.rsp0_zero !== 1'b1) begin n_err++; $display("[TB] FAIL sltu_big got=%h/%b exp=0/1", bus.rsp0_result, bus.rsp0_zero); end
    issue(0, 32'd1, 32'h8000_0000, 3'b100);
    n_cmp++; if (bus.rsp0_result !== 32'h1 || bus.rsp0_zero !== 1'b0) begin n_err++; $display("[TB] FAIL sltu_small got=%h/%b exp=1/0", bus.rsp0_result, bus.rsp0_zero); end
    issue(0, 32'h1, 32'h2, 3'b011);
    n_cmp++; if (bus.rsp0_result !== 32'h3) begin n_err++; $display("[TB] FAIL or got=%h exp=3", bus.rsp0_result); end
    idle_cycle();
  endtask

  task automatic test_mid_reset();
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
    issue(0, 32'd7, 32'd5, 3'b000);
    n_cmp++; if (bus.rsp0_valid !== 1'b1) begin n_err++; $display("[TB] FAIL mr_full got=%b exp=1", bus.rsp0_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.rsp0_valid !== 1'b0 || bus.rsp0_result !== 32'h0) begin n_err++; $display("[TB] FAIL mr_async_clear got=%b/%h exp=0/0", bus.rsp0_valid, bus.rsp0_result); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'hF0; bus.req0_b = 32'h3C; bus.req0_sel = 3'b010;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd2;  bus.req1_b = 32'hFFFF_FFFF; bus.req1_sel = 3'b100;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_err++; $display("[TB] FAIL mr_tie_ready got=%b%b exp=01", bus.req1_ready, bus.req0_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'h30) begin n_err++; $display("[TB] FAIL mr_first got=%b/%h exp=1/30", bus.rsp0_valid, bus.rsp0_result); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 32'h1) begin n_err++; $display("[TB] FAIL mr_second got=%b/%h exp=1/1", bus.rsp1_valid, bus.rsp1_result); end
    idle_cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_sltu_or();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
